cla_seq_adder: RTL and testbench
================================

# cla_seq_adder

Multi-cycle sequential adder that shares one `cla_4bit` slice across all nibbles of a WIDTH-bit operand pair. It adds one nibble per clock, least-significant first, and chains the carry through a register. It uses a valid/ready handshake on both input and output. It is the area-optimised alternative to a fully unrolled carry-lookahead chain, for datapaths that can tolerate WIDTH/4 cycles of latency.

## Interface

**Parameters**
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and ≥ 4; an elaboration-time check fails otherwise.

**Ports**
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- a  input  WIDTH  addend A, unsigned/two's complement.
- b  input  WIDTH  addend B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result held on sum/c_out/ovf.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + c_in, modulo 2^WIDTH.
- c_out  output  1  unsigned carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
- busy  output  1  state is not IDLE.

## Operation

- NIB = WIDTH/4. The FSM has three states: IDLE, CALC, DONE.
- **IDLE:** in_ready=1. On in_valid&in_ready the block:
  - captures a into op_a, b into op_b, c_in into carry_q;
  - captures sign bits a[MSB] and b[MSB] for ovf;
  - clears nib_cnt to 0 and goes to CALC.
  - in_valid without in_ready is ignored.
- **CALC:** the single `cla_4bit` slice sees op_a[3:0], op_b[3:0] and carry_q. At each edge:
  - its 4-bit sum is shifted into the top nibble of sum_q (right shift by 4);
  - op_a and op_b shift right by 4;
  - carry_q takes the slice c_out;
  - nib_cnt increments.
  - When nib_cnt==NIB-1 at the edge, go to DONE.
- **DONE:** out_valid=1. sum=sum_q and c_out=carry_q, both stable. ovf is computed from the captured sign bits and sum_q[MSB] and registered on entry to DONE. On out_valid&out_ready, go to IDLE. While out_ready=0, all outputs hold indefinitely.
- **Input stability:** in_valid/a/b/c_in are sampled only on the accept edge. Changes afterwards have no effect.
- **Output ordering:** out_ready is don't-care outside DONE. The result is never dropped or overwritten before the output handshake.
- **Reset** (asynchronous, any state, including mid-CALC):
  - state=IDLE, nib_cnt=0;
  - op_a, op_b, sum_q, carry_q and ovf register = 0;
  - the in-flight operation is discarded.
- **Output values during reset:** in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, busy=0.
- **Arithmetic:** a full carry chain of NIB slices is equivalent to WIDTH-bit addition. Results wrap modulo 2^WIDTH. c_out=1 exactly when a+b+c_in ≥ 2^WIDTH.

## Timing

- Let the accept edge be T. CALC occupies the cycles after edges T … T+NIB-1.
- out_valid first rises after edge T+NIB. Latency from acceptance to result is NIB cycles (4 for WIDTH=16).
- If out_ready is high at DONE entry, the output handshake completes at edge T+NIB+1. in_ready rises in the following cycle.
- Peak throughput is one operation per NIB+2 cycles. There is no overlap: in_ready=0 throughout CALC and DONE.
- Critical path is one `cla_4bit` plus the carry_q register, independent of WIDTH.
- nib_cnt width is clog2(NIB), minimum 1.

## Structure

- **Shared package `cla_pkg`:**
  - the `cla_state_t` enum (IDLE, CALC, DONE);
  - localparam NIBBLE_W=4;
  - a function returning clog2(WIDTH/NIBBLE_W) for counter sizing.
- **Sub-module:** exactly one instance of the existing `cla_4bit`, port-mapped to the low nibbles of the shift registers and to carry_q.
- **Everything else is in this module:**
  - the FSM;
  - nib_cnt;
  - the three WIDTH-bit shift registers;
  - carry_q and the ovf register.

## Test plan

All scenarios use WIDTH=16.

- **Basic add:** a=0x00FF, b=0x0001, c_in=0, out_ready=1 → sum=0x0100, c_out=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- **Full wrap:** a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Also a=0x1234, b=0x4321, c_in=1 → sum=0x5556, c_out=0.
- **Signed overflow:**
  - a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, c_out=0;
  - a=0x8000, b=0x8000 → sum=0x0000, ovf=1, c_out=1.
- **Backpressure:** hold out_ready=0 for 10 cycles in DONE and toggle a/b/in_valid meanwhile. Required: sum/c_out/ovf stable, in_ready=0, no second accept. Then out_ready=1 → IDLE with in_ready=1 on the next cycle.
- **Reset mid-CALC:** assert rst_n=0 after 2 CALC cycles. All outputs go to their reset values immediately, without waiting for a clock edge. After release, a new add of 0x0F0F+0x00F1 gives 0x1000 with no stale carry.
- **Random:** 1000 random (a, b, c_in) with random in_valid/out_ready gaps. Compare each result against the 17-bit reference sum; exactly one result per accepted input, in order.

Source files
------------

// File: rtl/cla_seq_adder_pkg.sv
// cla_pkg: shared FSM state type and sizing helpers for the nibble-serial adder
package cla_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} cla_state_t;
  localparam int NIBBLE_W = 4;
  function automatic int cnt_w(input int width);
    return (width / NIBBLE_W > 1) ? $clog2(width / NIBBLE_W) : 1;
  endfunction
endpackage

// File: rtl/cla_seq_adder_if.sv
// cla_seq_adder_if: operand/result valid-ready bus of the nibble-serial adder
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic c_in;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic c_out;
  logic ovf;
  logic busy;
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input in_ready, out_valid, sum, c_out, ovf, busy
  );
  modport slave (
    input in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
endinterface

// File: rtl/cla_seq_adder_cla_4bit.sv
// cla_4bit: 4-bit carry-lookahead adder slice
module cla_4bit (
  input logic [3:0] a,
  input logic [3:0] b,
  input logic c_in,
  output logic [3:0] sum,
  output logic c_out
);
  logic [3:0] g, p;
  logic [4:1] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p & c_in);
  assign sum = p ^ {c[3:1], c_in};
  assign c_out = c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: adds one nibble per clock through a single shared cla_4bit,
// chaining the carry in a register; result held until the output handshake.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  cla_seq_adder_if.slave bus
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW = cnt_w(WIDTH);
  if (WIDTH % NIBBLE_W != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end
  cla_state_t state;
  logic [CW-1:0] nib_cnt;
  logic [WIDTH-1:0] op_a, op_b, sum_q;
  logic carry_q, sign_a, sign_b, ovf_q;
  logic [3:0] nib_sum;
  logic nib_c;
  logic last;
  cla_4bit u_cla (
    .a(op_a[3:0]),
    .b(op_b[3:0]),
    .c_in(carry_q),
    .sum(nib_sum),
    .c_out(nib_c)
  );
  assign last = nib_cnt == CW'(NIB - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      nib_cnt <= '0;
      op_a <= '0;
      op_b <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_a <= bus.a;
          op_b <= bus.b;
          carry_q <= bus.c_in;
          sign_a <= bus.a[WIDTH-1];
          sign_b <= bus.b[WIDTH-1];
          nib_cnt <= '0;
          state <= CALC;
        end
        CALC: begin
          sum_q <= (sum_q >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));
          op_a <= op_a >> NIBBLE_W;
          op_b <= op_b >> NIBBLE_W;
          carry_q <= nib_c;
          nib_cnt <= nib_cnt + CW'(1);
          // the final slice sum supplies the result MSB, so overflow is known here
          if (last) begin
            ovf_q <= (sign_a == sign_b) && (nib_sum[3] != sign_a);
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.sum = sum_q;
  assign bus.c_out = carry_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed vector table plus backpressure, mid-CALC reset and random runs
module tb_cla_seq_adder;
  localparam int W = 16;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic ci;
    logic [W-1:0] s;
    logic co;
    logic ov;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int accepts = 0;
  int results = 0;
  cla_seq_adder_if #(.WIDTH(W)) bus ();
  cla_seq_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) accepts++;
    if (rst_n && bus.out_valid && bus.out_ready) results++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int hold,
                       output logic [W-1:0] s, output logic co, output logic ov, output int lat);
    logic [W-1:0] s0;
    logic c0, o0;
    int n;
    bus.a = a;
    bus.b = b;
    bus.c_in = ci;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) chk("result_timeout", 32'd0, 32'd1);
    s0 = bus.sum;
    c0 = bus.c_out;
    o0 = bus.ovf;
    for (int i = 0; i < hold; i++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.c_in = 1'($urandom);
      bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", {15'd0, bus.c_out, bus.sum}, {15'd0, c0, s0});
      chk("bp_ovf", 32'(bus.ovf), 32'(o0));
    end
    bus.in_valid = 1'b0;
    s = bus.sum;
    co = bus.c_out;
    ov = bus.ovf;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_sum"}, 32'(bus.sum), 32'd0);
    chk({tag, "_c_out"}, 32'(bus.c_out), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask
  initial begin
    vec_t tbl[9];
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    logic [W:0] ref_sum;
    logic ref_ov;
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].ci, 0, s, co, ov, lat);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(tbl[i].s));
      chk($sformatf("vec%0d_c_out", i), 32'(co), 32'(tbl[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end
    do_op(16'h8000, 16'h8000, 1'b0, 10, s, co, ov, lat);
    chk("bp_final", {14'd0, ov, co, s}, {14'd0, 1'b1, 1'b1, 16'h0000});
    bus.a = 16'hFFFF;
    bus.b = 16'h0001;
    bus.c_in = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("mid_calc_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    chk_reset_outputs("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0F0F, 16'h00F1, 1'b0, 0, s, co, ov, lat);
    chk("after_rst", {15'd0, co, s}, {15'd0, 1'b0, 16'h1000});
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_op(ra, rb, rc, int'($urandom_range(0, 2)), s, co, ov, lat);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      ref_ov = (ra[W-1] == rb[W-1]) && (ref_sum[W-1] != ra[W-1]);
      chk($sformatf("rnd%0d_result", k), {15'd0, co, s}, {15'd0, ref_sum});
      chk($sformatf("rnd%0d_ovf", k), 32'(ov), 32'(ref_ov));
    end
    @(posedge clk); #1;
    chk("accept_vs_result_count", 32'(accepts), 32'(results + 1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
